// File: rtl/agu_station_if.sv
// Dispatch, CDB wakeup and address-result bundle between the rename/dispatch
// stage (master) and the address-generation reservation station (slave).
interface agu_station_if;
  logic        dispatch_valid;
  logic [6:0]  dispatch_opcode;
  logic [31:0] dispatch_imm;
  logic [5:0]  dispatch_ps1;
  logic [5:0]  dispatch_ps2;
  logic        dispatch_ps1_ready;
  logic        dispatch_ps2_ready;
  logic [31:0] dispatch_ps1_v;
  logic [31:0] dispatch_ps2_v;
  logic [5:0]  dispatch_mem_idx;
  logic        cdb_valid;
  logic [5:0]  cdb_pd;
  logic [31:0] cdb_v;
  logic        full;
  logic        addr_valid;
  logic [31:0] addr;
  logic [5:0]  mem_idx;
  logic [31:0] store_wdata;
  logic [31:0] rs1_rdata;
  logic [31:0] rs2_rdata;

  modport master (
    output dispatch_valid, dispatch_opcode, dispatch_imm,
           dispatch_ps1, dispatch_ps2, dispatch_ps1_ready, dispatch_ps2_ready,
           dispatch_ps1_v, dispatch_ps2_v, dispatch_mem_idx,
           cdb_valid, cdb_pd, cdb_v,
    input  full, addr_valid, addr, mem_idx, store_wdata, rs1_rdata, rs2_rdata
  );

  modport slave (
    input  dispatch_valid, dispatch_opcode, dispatch_imm,
           dispatch_ps1, dispatch_ps2, dispatch_ps1_ready, dispatch_ps2_ready,
           dispatch_ps1_v, dispatch_ps2_v, dispatch_mem_idx,
           cdb_valid, cdb_pd, cdb_v,
    output full, addr_valid, addr, mem_idx, store_wdata, rs1_rdata, rs2_rdata
  );
endinterface

// File: rtl/agu_station.sv
// Reservation station for loads/stores: waits for both sources, picks the
// lowest ready entry each cycle and produces its effective address two edges on.
module agu_station #(
  parameter int NUM_ENTRIES = 8
) (
  input logic         clk,
  input logic         rst,
  agu_station_if.slave bus
);
  localparam int         IDX_W      = $clog2(NUM_ENTRIES);
  localparam logic [6:0] OP_B_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_B_STORE = 7'b0100011;

  typedef struct packed {
    logic [5:0]  ps;
    logic        ready;
    logic [31:0] v;
  } src_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [31:0] imm;
    logic [5:0]  mem_idx;
    src_t        s1;
    src_t        s2;
  } entry_t;

  logic [NUM_ENTRIES-1:0] valid_q;
  entry_t                 entry_q [NUM_ENTRIES];
  entry_t                 new_entry;
  logic                   alloc_hit, sel_hit, do_alloc;
  logic [IDX_W-1:0]       alloc_idx, sel_idx;

  logic        iss_valid_q, iss_store_q;
  logic [31:0] iss_imm_q, iss_rs1_q, iss_rs2_q;
  logic [5:0]  iss_mem_idx_q;

  // Physical register 0 is hard-wired and never broadcast, so it never wakes.
  function automatic src_t wake(src_t s, logic cv, logic [5:0] pd, logic [31:0] v);
    wake = s;
    if (cv && !s.ready && s.ps != 6'd0 && s.ps == pd) begin
      wake.ready = 1'b1;
      wake.v     = v;
    end
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    alloc_hit = 1'b0;
    alloc_idx = '0;
    sel_hit   = 1'b0;
    sel_idx   = '0;
    // Descending scan: the last hit written is the lowest index.
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        alloc_hit = 1'b1;
        alloc_idx = IDX_W'(i);
      end
      if (valid_q[i] && entry_q[i].s1.ready && entry_q[i].s2.ready) begin
        sel_hit = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign bus.full = &valid_q;
  assign do_alloc = bus.dispatch_valid && alloc_hit;

  always_comb begin
    new_entry.opcode  = bus.dispatch_opcode;
    new_entry.imm     = bus.dispatch_imm;
    new_entry.mem_idx = bus.dispatch_mem_idx;
    new_entry.s1 = wake({bus.dispatch_ps1, bus.dispatch_ps1_ready, bus.dispatch_ps1_v},
                        bus.cdb_valid, bus.cdb_pd, bus.cdb_v);
    new_entry.s2 = wake({bus.dispatch_ps2, bus.dispatch_ps2_ready, bus.dispatch_ps2_v},
                        bus.cdb_valid, bus.cdb_pd, bus.cdb_v);
    if (bus.dispatch_opcode == OP_B_LOAD) new_entry.s2 = {bus.dispatch_ps2, 1'b1, 32'd0};
  end

  // NOTE: the entry payload is storage qualified by valid_q and is deliberately
  // left out of reset; only the valid bits need a known value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (do_alloc && alloc_idx == IDX_W'(i)) begin
        entry_q[i] <= new_entry;
      end else begin
        entry_q[i].s1 <= wake(entry_q[i].s1, bus.cdb_valid, bus.cdb_pd, bus.cdb_v);
        entry_q[i].s2 <= wake(entry_q[i].s2, bus.cdb_valid, bus.cdb_pd, bus.cdb_v);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      // The allocated slot was invalid, so it can never be the selected one.
      if (sel_hit)  valid_q[sel_idx]   <= 1'b0;
      if (do_alloc) valid_q[alloc_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) iss_valid_q <= 1'b0;
    else     iss_valid_q <= sel_hit;
  end

  always_ff @(posedge clk) begin
    if (sel_hit) begin
      iss_store_q   <= (entry_q[sel_idx].opcode == OP_B_STORE);
      iss_imm_q     <= entry_q[sel_idx].imm;
      iss_mem_idx_q <= entry_q[sel_idx].mem_idx;
      iss_rs1_q     <= entry_q[sel_idx].s1.v;
      iss_rs2_q     <= entry_q[sel_idx].s2.v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.addr_valid  <= 1'b0;
      bus.addr        <= '0;
      bus.mem_idx     <= '0;
      bus.store_wdata <= '0;
      bus.rs1_rdata   <= '0;
      bus.rs2_rdata   <= '0;
    end else begin
      bus.addr_valid <= iss_valid_q;
      if (iss_valid_q) begin
        bus.addr        <= iss_rs1_q + iss_imm_q;
        bus.mem_idx     <= iss_mem_idx_q;
        bus.store_wdata <= iss_store_q ? iss_rs2_q : 32'd0;
        bus.rs1_rdata   <= iss_rs1_q;
        bus.rs2_rdata   <= iss_rs2_q;
      end
    end
  end
endmodule

// File: tb/tb_agu_station.sv
// Self-checking bench for agu_station: directed vectors, multi-cycle corner
// sequences and random traffic against an entry-table reference model.
module tb_agu_station;
  localparam int         NE       = 8;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  agu_station_if bus ();
  agu_station #(.NUM_ENTRIES(NE)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit        valid;
    bit [6:0]  op;
    bit [31:0] imm;
    bit [5:0]  midx;
    bit [5:0]  ps1, ps2;
    bit        r1, r2;
    bit [31:0] v1, v2;
  } m_ent_t;

  typedef struct packed {
    bit [31:0] addr, wd, r1, r2;
    bit [5:0]  midx;
  } out_t;

  m_ent_t m [NE];
  bit     pend_v, exp_av;
  out_t   pend, expo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: applies one clock edge's worth of the station's rules.
  task automatic model_edge();
    int sel, alc;
    sel = -1;
    alc = -1;
    if (rst) begin
      for (int i = 0; i < NE; i++) m[i].valid = 1'b0;
      pend_v = 1'b0;
      exp_av = 1'b0;
      expo   = '0;
      return;
    end
    exp_av = pend_v;
    if (pend_v) expo = pend;
    for (int i = NE - 1; i >= 0; i--) begin
      if (m[i].valid && m[i].r1 && m[i].r2) sel = i;
      if (!m[i].valid) alc = i;
    end
    pend_v = (sel >= 0);
    if (sel >= 0) begin
      pend.addr = m[sel].v1 + m[sel].imm;
      pend.wd   = (m[sel].op == OP_STORE) ? m[sel].v2 : 32'd0;
      pend.r1   = m[sel].v1;
      pend.r2   = m[sel].v2;
      pend.midx = m[sel].midx;
      m[sel].valid = 1'b0;
    end
    if (bus.cdb_valid && bus.cdb_pd != 0) begin
      for (int i = 0; i < NE; i++) begin
        if (m[i].valid && !m[i].r1 && m[i].ps1 == bus.cdb_pd) begin m[i].r1 = 1; m[i].v1 = bus.cdb_v; end
        if (m[i].valid && !m[i].r2 && m[i].ps2 == bus.cdb_pd) begin m[i].r2 = 1; m[i].v2 = bus.cdb_v; end
      end
    end
    if (bus.dispatch_valid && alc >= 0) begin
      m[alc].valid = 1'b1;
      m[alc].op    = bus.dispatch_opcode;
      m[alc].imm   = bus.dispatch_imm;
      m[alc].midx  = bus.dispatch_mem_idx;
      m[alc].ps1   = bus.dispatch_ps1;
      m[alc].ps2   = bus.dispatch_ps2;
      m[alc].r1    = bus.dispatch_ps1_ready;
      m[alc].v1    = bus.dispatch_ps1_v;
      m[alc].r2    = bus.dispatch_ps2_ready;
      m[alc].v2    = bus.dispatch_ps2_v;
      if (!m[alc].r1 && bus.cdb_valid && bus.cdb_pd != 0 && bus.cdb_pd == m[alc].ps1) begin
        m[alc].r1 = 1'b1; m[alc].v1 = bus.cdb_v;
      end
      if (!m[alc].r2 && bus.cdb_valid && bus.cdb_pd != 0 && bus.cdb_pd == m[alc].ps2) begin
        m[alc].r2 = 1'b1; m[alc].v2 = bus.cdb_v;
      end
      if (m[alc].op == OP_LOAD) begin m[alc].r2 = 1'b1; m[alc].v2 = 32'd0; end
    end
  endtask

  task automatic compare_all();
    bit mfull;
    mfull = 1'b1;
    for (int i = 0; i < NE; i++) if (!m[i].valid) mfull = 1'b0;
    check("full",        bus.full,        mfull);
    check("addr_valid",  bus.addr_valid,  exp_av);
    check("addr",        bus.addr,        expo.addr);
    check("mem_idx",     bus.mem_idx,     expo.midx);
    check("store_wdata", bus.store_wdata, expo.wd);
    check("rs1_rdata",   bus.rs1_rdata,   expo.r1);
    check("rs2_rdata",   bus.rs2_rdata,   expo.r2);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    bus.dispatch_valid     = 1'b0;
    bus.dispatch_opcode    = OP_LOAD;
    bus.dispatch_imm       = '0;
    bus.dispatch_ps1       = '0;
    bus.dispatch_ps2       = '0;
    bus.dispatch_ps1_ready = 1'b0;
    bus.dispatch_ps2_ready = 1'b0;
    bus.dispatch_ps1_v     = '0;
    bus.dispatch_ps2_v     = '0;
    bus.dispatch_mem_idx   = '0;
    bus.cdb_valid          = 1'b0;
    bus.cdb_pd             = '0;
    bus.cdb_v              = '0;
  endtask

  task automatic drive_disp(input bit [6:0] op, input bit [31:0] imm,
                            input bit [5:0] ps1, input bit r1, input bit [31:0] v1,
                            input bit [5:0] ps2, input bit r2, input bit [31:0] v2,
                            input bit [5:0] midx);
    bus.dispatch_valid     = 1'b1;
    bus.dispatch_opcode    = op;
    bus.dispatch_imm       = imm;
    bus.dispatch_ps1       = ps1;
    bus.dispatch_ps1_ready = r1;
    bus.dispatch_ps1_v     = v1;
    bus.dispatch_ps2       = ps2;
    bus.dispatch_ps2_ready = r2;
    bus.dispatch_ps2_v     = v2;
    bus.dispatch_mem_idx   = midx;
  endtask

  task automatic drive_cdb(input bit [5:0] pd, input bit [31:0] v);
    bus.cdb_valid = 1'b1;
    bus.cdb_pd    = pd;
    bus.cdb_v     = v;
  endtask

  typedef struct {
    bit [6:0]  op;
    bit [31:0] imm, v1;
    bit        r2;
    bit [31:0] v2;
    bit [5:0]  midx;
    bit [31:0] e_addr, e_wd, e_r2;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{OP_LOAD,  32'hFFFF_FFFC, 32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 6'd5,
                32'h0000_0FFC, 32'h0, 32'h0};
    vecs[1] = '{OP_STORE, 32'h0000_0008, 32'h0000_2000, 1'b1, 32'h0000_00AB, 6'd1,
                32'h0000_2008, 32'hAB, 32'hAB};
    vecs[2] = '{OP_STORE, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h1234_5678, 6'd63,
                32'h0000_0000, 32'h1234_5678, 32'h1234_5678};
    vecs[3] = '{OP_LOAD,  32'h0000_0010, 32'hFFFF_FFF8, 1'b0, 32'h0000_0055, 6'd0,
                32'h0000_0008, 32'h0, 32'h0};

    idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check("reset_full", bus.full, 1'b0);
    check("reset_addr_valid", bus.addr_valid, 1'b0);

    // Single ready ops: pulse lands two edges after dispatch.
    foreach (vecs[k]) begin
      drive_disp(vecs[k].op, vecs[k].imm, 6'd1, 1'b1, vecs[k].v1, 6'd2, vecs[k].r2, vecs[k].v2, vecs[k].midx);
      cycle();
      idle();
      cycle();
      check("tbl_early", bus.addr_valid, 1'b0);
      cycle();
      check("tbl_av",    bus.addr_valid,  1'b1);
      check("tbl_addr",  bus.addr,        vecs[k].e_addr);
      check("tbl_midx",  bus.mem_idx,     vecs[k].midx);
      check("tbl_wdata", bus.store_wdata, vecs[k].e_wd);
      check("tbl_rs1",   bus.rs1_rdata,   vecs[k].v1);
      check("tbl_rs2",   bus.rs2_rdata,   vecs[k].e_r2);
      cycle();
      check("tbl_pulse", bus.addr_valid, 1'b0);
    end

    // Wakeup through the CDB.
    drive_disp(OP_STORE, 32'd8, 6'd7, 1'b0, 32'd0, 6'd9, 1'b1, 32'hAB, 6'd2);
    cycle();
    idle();
    cycle();
    drive_cdb(6'd7, 32'h2000);
    cycle();
    idle();
    cycle();
    check("wake_early", bus.addr_valid, 1'b0);
    cycle();
    check("wake_av",    bus.addr_valid,  1'b1);
    check("wake_addr",  bus.addr,        32'h2008);
    check("wake_wdata", bus.store_wdata, 32'hAB);
    cycle();

    // Same-cycle bypass at dispatch.
    drive_disp(OP_LOAD, 32'd4, 6'd3, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd6);
    drive_cdb(6'd3, 32'h40);
    cycle();
    idle();
    cycle();
    cycle();
    check("bypass_av",   bus.addr_valid, 1'b1);
    check("bypass_addr", bus.addr,       32'h44);
    cycle();

    // Fill, drop the extra dispatch, free one entry, refill.
    for (int k = 0; k < NE; k++) begin
      drive_disp(OP_LOAD, 32'(k), 6'(20 + k), 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 6'(k));
      cycle();
    end
    idle();
    check("fill_full", bus.full, 1'b1);
    drive_disp(OP_LOAD, 32'd0, 6'd1, 1'b1, 32'h999, 6'd0, 1'b1, 32'd0, 6'd9);
    cycle();
    idle();
    check("fill_drop_full", bus.full, 1'b1);
    drive_cdb(6'd20, 32'h3000);
    cycle();
    idle();
    check("fill_still_full", bus.full, 1'b1);
    cycle();
    check("fill_freed", bus.full, 1'b0);
    drive_disp(OP_LOAD, 32'd0, 6'd1, 1'b1, 32'h500, 6'd0, 1'b1, 32'd0, 6'd11);
    cycle();
    idle();
    check("fill_refull", bus.full, 1'b1);
    for (int k = 1; k < NE; k++) begin
      drive_cdb(6'(20 + k), 32'(k * 16));
      cycle();
    end
    idle();
    repeat (5) cycle();

    // Entries 2 and 5 wake together: back-to-back pulses, lower index first.
    for (int k = 0; k < 6; k++) begin
      drive_disp(OP_LOAD, 32'd0, (k == 2 || k == 5) ? 6'd40 : 6'(30 + k), 1'b0, 32'd0,
                 6'd0, 1'b0, 32'd0, 6'(k));
      cycle();
    end
    drive_cdb(6'd40, 32'h7000);
    idle();
    drive_cdb(6'd40, 32'h7000);
    cycle();
    idle();
    cycle();
    cycle();
    check("order_av1",   bus.addr_valid, 1'b1);
    check("order_first", bus.mem_idx,    6'd2);
    cycle();
    check("order_av2",   bus.addr_valid, 1'b1);
    check("order_next",  bus.mem_idx,    6'd5);
    foreach (m[k]) begin end
    for (int k = 0; k < 5; k++) begin
      if (k != 2) begin
        drive_cdb(6'(30 + k), 32'(k));
        cycle();
      end
    end
    idle();
    repeat (5) cycle();

    // Reset lands on the edge where a ready entry is being selected.
    drive_disp(OP_LOAD, 32'd0, 6'd50, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd1);
    cycle();
    drive_disp(OP_LOAD, 32'd0, 6'd51, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd2);
    cycle();
    drive_disp(OP_LOAD, 32'd0, 6'd1, 1'b1, 32'h100, 6'd0, 1'b1, 32'd0, 6'd3);
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rstmid_full", bus.full, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("rstmid_av", bus.addr_valid, 1'b0);
    end
    drive_cdb(6'd50, 32'h1);
    cycle();
    drive_cdb(6'd51, 32'h2);
    cycle();
    idle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("rstmid_stale", bus.addr_valid, 1'b0);
    end

    // Random traffic against the model.
    for (int t = 0; t < 600; t++) begin
      bit [5:0] p1, p2;
      bit       q1;
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 1) == 1) begin
        p1 = 6'($urandom_range(0, 15));
        p2 = 6'($urandom_range(0, 15));
        q1 = (p1 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        drive_disp($urandom_range(0, 1) ? OP_STORE : OP_LOAD, $urandom,
                   p1, q1, $urandom, p2, (p2 == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                   $urandom, 6'($urandom_range(0, 63)));
      end else begin
        bus.dispatch_valid = 1'b0;
      end
      bus.cdb_valid = ($urandom_range(0, 2) == 0);
      bus.cdb_pd    = 6'($urandom_range(0, 15));
      bus.cdb_v     = $urandom;
      cycle();
    end
    rst = 1'b0;
    idle();
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
